// File: rtl/mem_responder.sv
// Memory-side bus target: decodes an address window, serves reads/writes from an
// internal RAM after a fixed number of wait states, and answers with n_mem_rdy.
module mem_responder #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                RAM_AW      = 11,
    parameter logic [ADDR_W-1:0] BASE        = '0,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              n_oe_mem,
    input  logic              n_we_mem,
    output logic [DATA_W-1:0] d_out,
    output logic              n_oe_d_out,
    output logic              n_mem_rdy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic [RAM_AW-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [DATA_W-1:0]   d_out_q, d_out_d;
    logic                n_mem_rdy_q, n_mem_rdy_d;
    logic                n_oe_d_out_q, n_oe_d_out_d;
    logic                err_q, err_d;
    logic                ram_we;
    logic                sel;
    logic                act_n;
    logic                opp_n;

    logic [DATA_W-1:0]   ram [2**RAM_AW];

    assign sel   = (addr[ADDR_W-1:RAM_AW] == BASE[ADDR_W-1:RAM_AW]);
    // Strobe that started the access versus the one that must stay quiet.
    assign act_n = rd_q ? n_oe_mem : n_we_mem;
    assign opp_n = rd_q ? n_we_mem : n_oe_mem;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        d_d     = d_q;
        d_out_d = d_out_q;
        err_d   = err_q;
        ram_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    if (!n_oe_mem && !n_we_mem) begin
                        err_d = 1'b1;
                    end else if (n_oe_mem ^ n_we_mem) begin
                        a_d     = addr[RAM_AW-1:0];
                        d_d     = d_in;
                        rd_d    = ~n_oe_mem;
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (act_n) begin
                    state_d = ST_IDLE;
                end else if (!opp_n) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (rd_q) begin
                        d_out_d = ram[a_q];
                    end else begin
                        ram_we = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!opp_n) begin
                    err_d = 1'b1;
                end
                if (act_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered versions of "next state is DONE".
        n_mem_rdy_d  = (state_d != ST_DONE);
        n_oe_d_out_d = !((state_d == ST_DONE) && rd_d);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            rd_q         <= 1'b0;
            a_q          <= '0;
            d_q          <= '0;
            d_out_q      <= '0;
            n_mem_rdy_q  <= 1'b1;
            n_oe_d_out_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            a_q          <= a_d;
            d_q          <= d_d;
            d_out_q      <= d_out_d;
            n_mem_rdy_q  <= n_mem_rdy_d;
            n_oe_d_out_q <= n_oe_d_out_d;
            err_q        <= err_d;
        end
    end

    // NOTE: the RAM array has no reset; its contents survive rst by design.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[a_q] <= d_q;
        end
    end

    assign d_out      = d_out_q;
    assign n_oe_d_out = n_oe_d_out_q;
    assign n_mem_rdy  = n_mem_rdy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders share one bus (W=2 at 0x0000, W=0 at 0x0800,
// W=15 at 0x1000); a reference RAM model feeds a queue of expected read data.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  d_in;
    logic        n_oe_mem;
    logic        n_we_mem;

    logic [7:0]  dout_w [3];
    logic        noe_w  [3];
    logic        rdy_w  [3];
    logic        err_w  [3];

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mdl [int];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2), .BASE(16'h0000)) u_dut0 (
        .clk(clk), .rst(rst), .addr(addr), .d_in(d_in),
        .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem),
        .d_out(dout_w[0]), .n_oe_d_out(noe_w[0]), .n_mem_rdy(rdy_w[0]), .err(err_w[0])
    );

    mem_responder #(.WAIT_CYCLES(0), .BASE(16'h0800)) u_dut1 (
        .clk(clk), .rst(rst), .addr(addr), .d_in(d_in),
        .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem),
        .d_out(dout_w[1]), .n_oe_d_out(noe_w[1]), .n_mem_rdy(rdy_w[1]), .err(err_w[1])
    );

    mem_responder #(.WAIT_CYCLES(15), .BASE(16'h1000)) u_dut2 (
        .clk(clk), .rst(rst), .addr(addr), .d_in(d_in),
        .n_oe_mem(n_oe_mem), .n_we_mem(n_we_mem),
        .d_out(dout_w[2]), .n_oe_d_out(noe_w[2]), .n_mem_rdy(rdy_w[2]), .err(err_w[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 3;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full access on responder d; hold = extra cycles the strobe stays low in DONE.
    task automatic access(input int d, input logic [15:0] a, input bit is_rd,
                          input logic [7:0] wd, input bit scramble, input int hold);
        logic [7:0] exp_d;
        logic [7:0] kept;
        logic       exp_rdy;
        addr = a;
        d_in = wd;
        if (is_rd) begin
            n_oe_mem = 1'b0;
            exp_q.push_back(mdl[int'(a)]);
        end else begin
            n_we_mem = 1'b0;
        end
        tick();
        for (int i = 1; i <= lat_of(d); i++) begin
            if (scramble && i == 1) begin
                addr = a ^ 16'h0001;
                d_in = ~wd;
            end
            tick();
            exp_rdy = (i == lat_of(d)) ? 1'b0 : 1'b1;
            checks++;
            if (rdy_w[d] !== exp_rdy) begin
                failures++;
                $display("FAIL rdy_timing dut%0d addr=%h edge=%0d: got %b want %b",
                         d, a, i, rdy_w[d], exp_rdy);
            end
            for (int o = 0; o < 3; o++) begin
                if (o != d) begin
                    checks++;
                    if (rdy_w[o] !== 1'b1) begin
                        failures++;
                        $display("FAIL silent dut%0d during access to %h: got %b want 1",
                                 o, a, rdy_w[o]);
                    end
                end
            end
        end
        checks++;
        if (noe_w[d] !== !is_rd) begin
            failures++;
            $display("FAIL n_oe_d_out dut%0d addr=%h: got %b want %b", d, a, noe_w[d], !is_rd);
        end
        if (is_rd) begin
            exp_d = exp_q.pop_front();
            checks++;
            if (dout_w[d] !== exp_d) begin
                failures++;
                $display("FAIL read_data dut%0d addr=%h: got %h want %h", d, a, dout_w[d], exp_d);
            end
        end else begin
            mdl[int'(a)] = wd;
        end
        repeat (hold) begin
            tick();
            checks++;
            if (rdy_w[d] !== 1'b0) begin
                failures++;
                $display("FAIL held_strobe dut%0d: got rdy %b want 0", d, rdy_w[d]);
            end
        end
        kept     = dout_w[d];
        n_oe_mem = 1'b1;
        n_we_mem = 1'b1;
        tick();
        checks++;
        if (rdy_w[d] !== 1'b1 || noe_w[d] !== 1'b1 || dout_w[d] !== kept) begin
            failures++;
            $display("FAIL release dut%0d: got rdy=%b noe=%b dout=%h want 1 1 %h",
                     d, rdy_w[d], noe_w[d], dout_w[d], kept);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        addr     = '0;
        d_in     = '0;
        n_oe_mem = 1'b1;
        n_we_mem = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy_w[d] !== 1'b1 || noe_w[d] !== 1'b1 || dout_w[d] !== 8'h00 || err_w[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_values dut%0d: got rdy=%b noe=%b dout=%h err=%b want 1 1 00 0",
                         d, rdy_w[d], noe_w[d], dout_w[d], err_w[d]);
            end
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_read();
        access(0, 16'h0005, 1'b0, 8'hA5, 1'b0, 0);
        access(0, 16'h0005, 1'b1, 8'h00, 1'b0, 0);
    endtask

    task automatic test_write_read();
        access(0, 16'h07FE, 1'b0, 8'h5A, 1'b0, 0);
        access(0, 16'h07FF, 1'b0, 8'h3C, 1'b1, 0);
        access(0, 16'h07FF, 1'b1, 8'h00, 1'b0, 0);
        access(0, 16'h07FE, 1'b1, 8'h00, 1'b0, 0);
    endtask

    task automatic test_abort();
        access(0, 16'h0010, 1'b0, 8'h22, 1'b0, 0);
        addr     = 16'h0010;
        d_in     = 8'h11;
        n_we_mem = 1'b0;
        tick();
        tick();
        n_we_mem = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rdy_w[0] !== 1'b1) begin
                failures++;
                $display("FAIL abort_no_rdy cycle %0d: got %b want 1", i, rdy_w[0]);
            end
        end
        access(0, 16'h0010, 1'b1, 8'h00, 1'b0, 0);
    endtask

    task automatic test_protocol_error();
        addr     = 16'h0020;
        n_oe_mem = 1'b0;
        n_we_mem = 1'b0;
        tick();
        checks++;
        if (err_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL both_strobes: got err=%b rdy=%b want 1 1", err_w[0], rdy_w[0]);
        end
        tick();
        checks++;
        if (rdy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL both_strobes_no_access: got rdy %b want 1", rdy_w[0]);
        end
        n_oe_mem = 1'b1;
        n_we_mem = 1'b1;
        tick();
        access(0, 16'h0005, 1'b1, 8'h00, 1'b0, 0);
        checks++;
        if (err_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b want 1", err_w[0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        access(0, 16'h0040, 1'b0, 8'h44, 1'b0, 0);
        access(0, 16'h0040, 1'b1, 8'h00, 1'b0, 0);
        addr     = 16'h0040;
        d_in     = 8'h99;
        n_we_mem = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rdy_w[0] !== 1'b1 || noe_w[0] !== 1'b1 || dout_w[0] !== 8'h00 || err_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got rdy=%b noe=%b dout=%h err=%b want 1 1 00 0",
                     rdy_w[0], noe_w[0], dout_w[0], err_w[0]);
        end
        n_we_mem = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        access(0, 16'h0040, 1'b1, 8'h00, 1'b0, 0);
    endtask

    task automatic test_opposite_in_wait();
        access(0, 16'h0030, 1'b0, 8'h33, 1'b0, 0);
        addr     = 16'h0030;
        d_in     = 8'h77;
        n_we_mem = 1'b0;
        tick();
        n_oe_mem = 1'b0;
        tick();
        checks++;
        if (err_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL opposite_in_wait: got err=%b rdy=%b want 1 1", err_w[0], rdy_w[0]);
        end
        n_oe_mem = 1'b1;
        n_we_mem = 1'b1;
        tick();
        checks++;
        if (rdy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL opposite_abort_no_rdy: got %b want 1", rdy_w[0]);
        end
        access(0, 16'h0030, 1'b1, 8'h00, 1'b0, 0);
    endtask

    task automatic test_window();
        access(1, 16'h0805, 1'b0, 8'hC3, 1'b0, 0);
        access(1, 16'h0805, 1'b1, 8'h00, 1'b0, 0);
        access(0, 16'h0005, 1'b1, 8'h00, 1'b0, 0);
        access(2, 16'h1003, 1'b0, 8'h9E, 1'b0, 0);
        access(2, 16'h1003, 1'b1, 8'h00, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        access(0, 16'h0005, 1'b1, 8'h00, 1'b0, 4);
        access(0, 16'h07FF, 1'b1, 8'h00, 1'b0, 0);
        access(1, 16'h0805, 1'b1, 8'h00, 1'b0, 3);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_abort();
        test_protocol_error();
        test_reset_mid_wait();
        test_opposite_in_wait();
        test_window();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side bus target answering the CPU control unit's memory strobes (`n_oe_mem`, `n_we_mem`) and driving the `n_mem_rdy` handshake back to it. It decodes an address window, services reads and writes against an internal RAM, and inserts a parameterised number of wait states. It sits on the CPU's address/data bus next to other targets; outside its window it stays silent.

## Interface
- `ADDR_W`, 16: CPU address bus width.
- `DATA_W`, 8: data bus width.
- `RAM_AW`, 11: internal RAM address width, giving 2^RAM_AW words.
- `BASE`, 16'h0000: window base. Must be aligned to 2^RAM_AW.
- `WAIT_CYCLES`, 2: wait states per access. Allowed range 0..15.

Ports:
- `clk` in 1: clock. All state changes on posedge.
- `rst` in 1: asynchronous reset, active-high.
- `addr` in ADDR_W: CPU address bus.
- `d_in` in DATA_W: data driven by the CPU (write data).
- `n_oe_mem` in 1: read strobe, active low.
- `n_we_mem` in 1: write strobe, active low.
- `d_out` out DATA_W: read data toward the bus.
- `n_oe_d_out` out 1: bus drive enable for `d_out`, active low.
- `n_mem_rdy` out 1: access complete, active low.
- `err` out 1: sticky protocol-error flag.

## Operation
- `sel` is true when `addr[ADDR_W-1:RAM_AW] == BASE[ADDR_W-1:RAM_AW]`. The RAM index is `addr[RAM_AW-1:0]`.
- Strobes are level-sampled on posedge `clk`. The CPU holds a strobe until it sees `n_mem_rdy` low.
- The FSM has states IDLE, WAIT and DONE. A `cnt` register of 4 bits, plus registers `rd`, `a_q` and `d_q`, support it.

IDLE:
- If exactly one strobe is low and `sel` is true, the block captures `a_q <= addr` and `d_q <= d_in`, sets `rd <= ~n_oe_mem` and `cnt <= WAIT_CYCLES`, then moves to WAIT.
- If both strobes are low, it sets `err` and stays in IDLE.
- If `sel` is false, it stays in IDLE.

WAIT:
- If the active strobe is released, the access is aborted: move to IDLE, no write, no ready.
- If the opposite strobe is also low, set `err` and abort to IDLE.
- Otherwise, if `cnt != 0`, decrement `cnt`.
- If `cnt == 0`:
  - For a write, perform `ram[a_q] <= d_q`.
  - For a read, perform `d_out <= ram[a_q]`.
  - Then move to DONE.

DONE:
- `n_mem_rdy` is low. For a read, `n_oe_d_out` is also low.
- The block leaves DONE for IDLE on the first edge that samples the active strobe high.
- If the opposite strobe is sampled low while in DONE, set `err`. The completed access stands.

General rules:
- Address and write data are captured once, at acceptance. Bus changes during WAIT or DONE are ignored.
- `err` clears only on `rst`. It does not block further accesses.
- RAM contents are not reset.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `n_mem_rdy` = 1, `n_oe_d_out` = 1, `d_out` = 0, `err` = 0.
- Acceptance at edge T0 gives DONE at edge T0+WAIT_CYCLES+1. `n_mem_rdy` is low from that edge.
  - WAIT_CYCLES=0: ready one cycle after acceptance.
  - WAIT_CYCLES=15: ready 16 cycles after acceptance.
- `d_out` is registered and valid from the same edge `n_mem_rdy` falls. It stays stable until the next read completes.
- A write is committed on the WAIT→DONE edge. A read issued at the very next acceptance returns the new data.
- Release works as follows:
  - If the strobe is sampled high at edge T1 in DONE, then at T1 `n_mem_rdy` returns to 1 and `n_oe_d_out` returns to 1.
  - The earliest next acceptance is T1+1. A strobe held continuously low never starts a second access.
- `rst` asserted in any state drives all outputs to their reset values immediately. A write still in WAIT is not committed.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Test plan
- Read, WAIT_CYCLES=2, RAM[0x005]=0xA5:
  - Stimulus: `addr`=0x0005, `n_oe_mem`=0 sampled at T0.
  - Required: `n_mem_rdy`=1 at T0+1 and T0+2. `n_mem_rdy`=0, `n_oe_d_out`=0 and `d_out`=0xA5 at T0+3.
  - Release at T1: both controls return to 1 at T1.
- Write then read:
  - Stimulus: write 0x3C to 0x07FF, release, then read 0x07FF.
  - Required: `d_out`=0x3C. Also check that `addr`/`d_in` changed during WAIT have no effect.
- Abort:
  - Stimulus: write 0x11 to 0x0010, with the strobe released after one WAIT cycle.
  - Required: `n_mem_rdy` never goes low. A later read of 0x0010 returns the old value.
- Protocol error:
  - Stimulus: both strobes low in IDLE.
  - Required: `err`=1 on the next edge, no access, `err` held until `rst`.
  - Also: the opposite strobe asserted during WAIT aborts the access and sets `err`.
- Window:
  - Stimulus: BASE=16'h0800, read at 0x0005.
  - Required: no response, `n_mem_rdy`=1 throughout. A read at 0x0805 responds normally.
- Reset and corners:
  - Stimulus: `rst` pulsed mid-WAIT of a write.
  - Required: outputs return to reset values asynchronously and the RAM word is unchanged.
  - Also cover WAIT_CYCLES=0: ready at T0+1.
  - Also cover a strobe held low across DONE: exactly one access occurs.
